// File: rtl/axi_lite_user_bus_scheduler.sv
// AXI-lite user-bus scheduler: serialises AW/W/B and AR/R channels onto one
// single-ported synchronous memory port with round-robin AW/AR arbitration.
//
// Ports:
//   ACLK, ARESET            clock, synchronous active-high reset
//   aw*/w*/b*               write address, data and response channels
//   ar*/r*                  read address and data channels
//   mem_en/we/addr/wdata    memory port strobe, direction, word address, data
//   mem_rdata               memory read data, one cycle after a read strobe
module axi_lite_user_bus_scheduler #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH     = 10
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          awvalid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]                    awlen,
    output logic                          awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] wdata,
    input  logic                          wlast,
    input  logic                          wvalid,
    output logic                          wready,
    output logic                          bvalid,
    input  logic                          bready,
    input  logic                          arvalid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]                    arlen,
    output logic                          arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0] rdata,
    output logic                          rlast,
    output logic                          rvalid,
    input  logic                          rready,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] mem_wdata,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] mem_rdata
);

    localparam int SH = $clog2(C_S_AXI_DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RCAP,
        S_RDATA
    } state_t;

    state_t                    state;
    logic                      last_rd;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [7:0]                cnt;

    logic                          grant_w;
    logic                          grant_r;
    logic                          w_fire;
    logic [C_S_AXI_ADDR_WIDTH-1:0] aw_word;
    logic [C_S_AXI_ADDR_WIDTH-1:0] ar_word;
    logic                          unused_bits;

    assign aw_word = awaddr >> SH;
    assign ar_word = araddr >> SH;

    // Word addresses keep only the memory-port width; wlast is not used
    // because burst length comes from awlen.
    assign unused_bits = ^{wlast,
                           aw_word[C_S_AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                           ar_word[C_S_AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

    // On a tie the channel that did not win last time is served.
    assign grant_w = awvalid && (!arvalid || last_rd);
    assign grant_r = arvalid && (!awvalid || !last_rd);

    assign awready = (state == S_IDLE) && grant_w;
    assign arready = (state == S_IDLE) && grant_r;
    assign wready  = (state == S_WRITE);
    assign w_fire  = (state == S_WRITE) && wvalid;

    assign mem_en    = w_fire || (state == S_READ);
    assign mem_we    = w_fire;
    assign mem_addr  = mem_en ? addr : '0;
    assign mem_wdata = w_fire ? wdata : '0;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state   <= S_IDLE;
            last_rd <= 1'b1;
            addr    <= '0;
            len     <= '0;
            cnt     <= '0;
            bvalid  <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant_w) begin
                        addr    <= aw_word[MEM_ADDR_WIDTH-1:0];
                        len     <= awlen;
                        cnt     <= '0;
                        last_rd <= 1'b0;
                        state   <= S_WRITE;
                    end else if (grant_r) begin
                        addr    <= ar_word[MEM_ADDR_WIDTH-1:0];
                        len     <= arlen;
                        cnt     <= '0;
                        last_rd <= 1'b1;
                        state   <= S_READ;
                    end
                end
                S_WRITE: begin
                    if (wvalid) begin
                        addr <= addr + 1'b1;
                        cnt  <= cnt + 8'd1;
                        if (cnt == len) begin
                            bvalid <= 1'b1;
                            state  <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_READ: begin
                    state <= S_RCAP;
                end
                S_RCAP: begin
                    rdata  <= mem_rdata;
                    rlast  <= (cnt == len);
                    rvalid <= 1'b1;
                    state  <= S_RDATA;
                end
                S_RDATA: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        addr   <= addr + 1'b1;
                        cnt    <= cnt + 8'd1;
                        state  <= rlast ? S_IDLE : S_READ;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_user_bus_scheduler.sv
// Directed bench for axi_lite_user_bus_scheduler with a behavioural
// single-port memory behind the scheduler.
module tb_axi_lite_user_bus_scheduler;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        awready;
    logic [31:0] wdata;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] mem [1024];

    axi_lite_user_bus_scheduler dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .awvalid   (awvalid),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awready   (awready),
        .wdata     (wdata),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bvalid    (bvalid),
        .bready    (bready),
        .arvalid   (arvalid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arready   (arready),
        .rdata     (rdata),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw_req(input logic [31:0] a, input logic [7:0] l);
        awvalid = 1'b1;
        awaddr  = a;
        awlen   = l;
        @(negedge ACLK);
        chk("awready", awready, 1);
        chk("arready_in_aw", arready, 0);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic ar_req(input logic [31:0] a, input logic [7:0] l);
        arvalid = 1'b1;
        araddr  = a;
        arlen   = l;
        @(negedge ACLK);
        chk("arready", arready, 1);
        chk("awready_in_ar", awready, 0);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic write_data(input logic [9:0] word, input int len,
                              input logic [31:0] base);
        logic [9:0] wa;
        int n;
        for (int b = 0; b <= len; b++) begin
            wa     = word + 10'(b);
            wvalid = 1'b1;
            wdata  = base + 32'(b);
            @(negedge ACLK);
            chk("w_wready", wready, 1);
            chk("w_mem_en", mem_en, 1);
            chk("w_mem_we", mem_we, 1);
            chk("w_mem_addr", 32'(mem_addr), 32'(wa));
            chk("w_mem_wdata", mem_wdata, base + 32'(b));
            tick();
        end
        wvalid = 1'b0;
        n = 0;
        @(negedge ACLK);
        while (!bvalid && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        chk("bvalid_wait", bvalid, 1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        @(negedge ACLK);
        chk("bvalid_drop", bvalid, 0);
        tick();
    endtask

    task automatic read_beat(input logic [31:0] ed, input logic el,
                             input int stall);
        int n;
        n = 0;
        @(negedge ACLK);
        while (!rvalid && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        chk("rvalid_wait", rvalid, 1);
        for (int s = 0; s < stall; s++) begin
            chk("r_stall_rdata", rdata, ed);
            @(negedge ACLK);
            chk("r_stall_rvalid", rvalid, 1);
        end
        rready = 1'b1;
        chk("rdata", rdata, ed);
        chk("rlast", rlast, el);
        tick();
        rready = 1'b0;
    endtask

    initial begin
        logic ew;
        int n;
        ARESET  = 1'b1;
        awvalid = 1'b0;
        awaddr  = '0;
        awlen   = '0;
        wdata   = '0;
        wlast   = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0;
        araddr  = '0;
        arlen   = '0;
        rready  = 1'b0;
        tick();
        tick();
        ARESET = 1'b0;

        // Reset state while idle.
        @(negedge ACLK);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        tick();

        // Single write, response held with bready low.
        aw_req(32'h10, 8'd0);
        wvalid = 1'b1;
        wdata  = 32'hA5A5_A5A5;
        @(negedge ACLK);
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_addr", 32'(mem_addr), 4);
        chk("t2_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            chk("t2_bvalid_hold", bvalid, 1);
            chk("t2_mem_en_idle", mem_en, 0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        @(negedge ACLK);
        chk("t2_bvalid_drop", bvalid, 0);
        tick();

        // Fill words 8..15 with a burst.
        aw_req(32'h20, 8'd7);
        write_data(10'd8, 7, 32'h1000_0000);

        // Read burst with random stalls.
        ar_req(32'h20, 8'd3);
        for (int b = 0; b < 4; b++)
            read_beat(32'h1000_0000 + 32'(b), b == 3,
                      int'($urandom_range(0, 2)));
        @(negedge ACLK);
        chk("t3_rvalid_end", rvalid, 0);
        tick();

        // Simultaneous requests alternate W,R,W,R.
        for (int i = 0; i < 4; i++) begin
            ew      = (i % 2 == 0);
            awvalid = 1'b1;
            awaddr  = 32'h40 + 32'(4 * i);
            awlen   = 8'd0;
            arvalid = 1'b1;
            araddr  = 32'h10;
            arlen   = 8'd0;
            @(negedge ACLK);
            chk("t4_awready", awready, ew);
            chk("t4_arready", arready, !ew);
            chk("t4_not_both", awready & arready, 0);
            tick();
            awvalid = 1'b0;
            arvalid = 1'b0;
            if (ew) write_data(10'd16 + 10'(i), 0, 32'hB0 + 32'(i));
            else    read_beat(32'hA5A5_A5A5, 1'b1, 1);
        end

        // Address wrap at the top of memory.
        aw_req(32'hFFC, 8'd1);
        write_data(10'd1023, 1, 32'hC0DE_0000);

        // Reset during the third beat of an eight-beat read.
        ar_req(32'h20, 8'd7);
        read_beat(32'h1000_0000, 1'b0, 0);
        read_beat(32'h1000_0001, 1'b0, 1);
        n = 0;
        @(negedge ACLK);
        while (!rvalid && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        chk("t6_beat2_rvalid", rvalid, 1);
        chk("t6_beat2_rdata", rdata, 32'h1000_0002);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("t6_rvalid_rst", rvalid, 0);
        chk("t6_mem_en_rst", mem_en, 0);
        chk("t6_arready_rst", arready, 0);
        chk("t6_rdata_rst", rdata, 0);
        tick();

        // Follow-up read returns the wrapped write at word 0.
        ar_req(32'h0, 8'd0);
        read_beat(32'hC0DE_0001, 1'b1, 0);
        @(negedge ACLK);
        chk("t6_rvalid_end", rvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
